regfile_2w2r_sb: RTL and testbench

- Parametrised successor to the single-write MIPS register file.
- Two asynchronous read ports and two synchronous write ports: WB/ALU on port 0, load return on port 1.
- Port 0 has a link mode that redirects the write to the link register (JAL).
- A per-register busy scoreboard lets the pipeline stall on operands that still have a write pending.
- Optional write-to-read bypass.
- Sits in the decode stage, between instruction decode and the ID/EX register.

---
 rtl/regfile_2w2r_sb.sv | 115 +++++++++++
 tb/tb_regfile_2w2r_sb.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_2w2r_sb.sv
// regfile_2w2r_sb
// Decode-stage register file with a per-register busy scoreboard.
// There are two combinational read ports and two synchronous write ports.
// Port 0 carries WB/ALU results. Port 1 carries load returns.
//
// Optional macro REGFILE_BYPASS_EN enables write-first forwarding from the
// write ports to the read ports.
//
// Ports:
//   i_clk, i_rst                    clock, async active-high reset
//   i_rd_addr_a/b                   read addresses
//   o_rd_data_a/b, o_busy_a/b       read data and scoreboard bits
//   i_wr0_en/addr/data, i_link_en   write port 0 (link_en redirects to LINK_REG)
//   i_wr1_en/addr/data              write port 1 (load return, wins collisions)
//   i_busy_set, i_busy_addr         mark a register as having a pending producer
module regfile_2w2r_sb #(
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 32,
  parameter int ADDR_W   = 5,
  parameter int LINK_REG = 31
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [ADDR_W-1:0] i_rd_addr_a,
  input  logic [ADDR_W-1:0] i_rd_addr_b,
  output logic [DATA_W-1:0] o_rd_data_a,
  output logic [DATA_W-1:0] o_rd_data_b,
  output logic              o_busy_a,
  output logic              o_busy_b,
  input  logic              i_wr0_en,
  input  logic [ADDR_W-1:0] i_wr0_addr,
  input  logic [DATA_W-1:0] i_wr0_data,
  input  logic              i_link_en,
  input  logic              i_wr1_en,
  input  logic [ADDR_W-1:0] i_wr1_addr,
  input  logic [DATA_W-1:0] i_wr1_data,
  input  logic              i_busy_set,
  input  logic [ADDR_W-1:0] i_busy_addr
);

  localparam logic [ADDR_W-1:0] LP_LINK = ADDR_W'(LINK_REG);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DEPTH-1:0]  r_busy;
  logic [DEPTH-1:0]  w_busy_nxt;
  logic [ADDR_W-1:0] w_wr0_tgt;

  assign w_wr0_tgt = i_link_en ? LP_LINK : i_wr0_addr;

  // Entry 0 is never written, so it stays at its reset value of zero.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      for (int i = 1; i < DEPTH; i++) begin
        if (i_wr1_en && (i_wr1_addr == ADDR_W'(i)))
          r_mem[i] <= i_wr1_data;
        else if (i_wr0_en && (w_wr0_tgt == ADDR_W'(i)))
          r_mem[i] <= i_wr0_data;
      end
    end
  end

  // Clears are applied before the set, so a new producer issued in the
  // same cycle as an older write-back keeps the register busy.
  always_comb begin
    w_busy_nxt = r_busy;
    if (i_wr0_en) w_busy_nxt[w_wr0_tgt] = 1'b0;
    if (i_wr1_en) w_busy_nxt[i_wr1_addr] = 1'b0;
    if (i_busy_set) w_busy_nxt[i_busy_addr] = 1'b1;
    w_busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_busy <= '0;
    else       r_busy <= w_busy_nxt;
  end

  always_comb begin
    o_rd_data_a = (i_rd_addr_a == '0) ? '0 : r_mem[i_rd_addr_a];
    o_busy_a    = r_busy[i_rd_addr_a];
`ifdef REGFILE_BYPASS_EN
    // Forwarding is gated by reset so reads stay zero while reset is held.
    // wr1 is checked last so that it wins over wr0.
    if (!i_rst && (i_rd_addr_a != '0)) begin
      if (i_wr0_en && (w_wr0_tgt == i_rd_addr_a)) begin
        o_rd_data_a = i_wr0_data;
        o_busy_a    = 1'b0;
      end
      if (i_wr1_en && (i_wr1_addr == i_rd_addr_a)) begin
        o_rd_data_a = i_wr1_data;
        o_busy_a    = 1'b0;
      end
    end
`endif
  end

  always_comb begin
    o_rd_data_b = (i_rd_addr_b == '0) ? '0 : r_mem[i_rd_addr_b];
    o_busy_b    = r_busy[i_rd_addr_b];
`ifdef REGFILE_BYPASS_EN
    if (!i_rst && (i_rd_addr_b != '0)) begin
      if (i_wr0_en && (w_wr0_tgt == i_rd_addr_b)) begin
        o_rd_data_b = i_wr0_data;
        o_busy_b    = 1'b0;
      end
      if (i_wr1_en && (i_wr1_addr == i_rd_addr_b)) begin
        o_rd_data_b = i_wr1_data;
        o_busy_b    = 1'b0;
      end
    end
`endif
  end

endmodule

// File: tb/tb_regfile_2w2r_sb.sv
module tb_regfile_2w2r_sb;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  rd_addr_a, rd_addr_b;
  logic [31:0] rd_data_a, rd_data_b;
  logic        busy_a, busy_b;
  logic        wr0_en, link_en, wr1_en, busy_set;
  logic [4:0]  wr0_addr, wr1_addr, busy_addr;
  logic [31:0] wr0_data, wr1_data;

  int total = 0;
  int bad   = 0;

  typedef struct {
    string       tag;
    bit          port;
    logic [4:0]  addr;
    logic [31:0] data;
    logic        busy;
  } exp_t;

  exp_t sb_q[$];

  regfile_2w2r_sb dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_rd_addr_a (rd_addr_a),
    .i_rd_addr_b (rd_addr_b),
    .o_rd_data_a (rd_data_a),
    .o_rd_data_b (rd_data_b),
    .o_busy_a    (busy_a),
    .o_busy_b    (busy_b),
    .i_wr0_en    (wr0_en),
    .i_wr0_addr  (wr0_addr),
    .i_wr0_data  (wr0_data),
    .i_link_en   (link_en),
    .i_wr1_en    (wr1_en),
    .i_wr1_addr  (wr1_addr),
    .i_wr1_data  (wr1_data),
    .i_busy_set  (busy_set),
    .i_busy_addr (busy_addr)
  );

  always #5 clk = ~clk;

  task automatic push(input string tag, input bit port, input logic [4:0] addr,
                      input logic [31:0] data, input logic busy);
    exp_t e;
    e.tag = tag; e.port = port; e.addr = addr; e.data = data; e.busy = busy;
    sb_q.push_back(e);
  endtask

  task automatic check_q();
    exp_t        e;
    logic [31:0] obs_d;
    logic        obs_b;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      if (e.port) rd_addr_b = e.addr;
      else        rd_addr_a = e.addr;
      #1;
      obs_d = e.port ? rd_data_b : rd_data_a;
      obs_b = e.port ? busy_b : busy_a;
      total++;
      assert (obs_d === e.data) else begin
        bad++;
        $error("FAIL %s data got=%h exp=%h", e.tag, obs_d, e.data);
      end
      total++;
      assert (obs_b === e.busy) else begin
        bad++;
        $error("FAIL %s busy got=%b exp=%b", e.tag, obs_b, e.busy);
      end
    end
  endtask

  task automatic idle();
    wr0_en = 0; link_en = 0; wr1_en = 0; busy_set = 0;
    wr0_addr = 0; wr1_addr = 0; busy_addr = 0;
    wr0_data = 0; wr1_data = 0;
  endtask

  task automatic sync();
    @(negedge clk);
  endtask

  task automatic commit();
    @(posedge clk);
    #1;
    idle();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    rd_addr_a = 0; rd_addr_b = 0;
    idle();
    #1;
    push("rst_init_a", 0, 5'd5, 32'h0, 1'b0);
    push("rst_init_b", 1, 5'd31, 32'h0, 1'b0);
    check_q();
    sync();
    rst = 1'b0;

    // write port 0, same-cycle visibility then next-cycle visibility
    sync();
    wr0_en = 1; wr0_addr = 5; wr0_data = 32'd20;
`ifdef REGFILE_BYPASS_EN
    push("wr0_same_cycle", 0, 5'd5, 32'd20, 1'b0);
`else
    push("wr0_same_cycle", 0, 5'd5, 32'd0, 1'b0);
`endif
    check_q();
    commit();
    push("wr0_next_cycle", 0, 5'd5, 32'd20, 1'b0);
    check_q();

    // link mode
    sync();
    wr0_en = 1; link_en = 1; wr0_addr = 9; wr0_data = 32'h0040_0008;
    commit();
    push("link_r31", 0, 5'd31, 32'h0040_0008, 1'b0);
    push("link_r9", 1, 5'd9, 32'h0, 1'b0);
    check_q();
    sync();
    wr0_en = 0; link_en = 1; wr0_addr = 9; wr0_data = 32'hDEAD_BEEF;
    commit();
    push("link_noen_r31", 0, 5'd31, 32'h0040_0008, 1'b0);
    push("link_noen_r9", 1, 5'd9, 32'h0, 1'b0);
    check_q();

    // collision, register 0, independent dual write
    sync();
    wr0_en = 1; wr0_addr = 8; wr0_data = 32'd72;
    wr1_en = 1; wr1_addr = 8; wr1_data = 32'd100;
    commit();
    push("collide_r8", 1, 5'd8, 32'd100, 1'b0);
    check_q();
    sync();
    wr0_en = 1; wr0_addr = 0; wr0_data = 32'hFFFF_FFFF;
    wr1_en = 1; wr1_addr = 0; wr1_data = 32'hFFFF_FFFF;
    push("r0_write_a", 0, 5'd0, 32'h0, 1'b0);
    check_q();
    commit();
    push("r0_after_a", 0, 5'd0, 32'h0, 1'b0);
    push("r0_after_b", 1, 5'd0, 32'h0, 1'b0);
    check_q();
    sync();
    wr0_en = 1; wr0_addr = 10; wr0_data = 32'h0000_000A;
    wr1_en = 1; wr1_addr = 11; wr1_data = 32'h0000_000B;
    commit();
    push("dual_r10", 0, 5'd10, 32'h0000_000A, 1'b0);
    push("dual_r11", 1, 5'd11, 32'h0000_000B, 1'b0);
    check_q();

    // scoreboard
    sync();
    busy_set = 1; busy_addr = 7;
    commit();
    push("bset_r7", 0, 5'd7, 32'h0, 1'b1);
    check_q();
    sync();
    wr1_en = 1; wr1_addr = 7; wr1_data = 32'd77;
`ifdef REGFILE_BYPASS_EN
    push("wr1_same_r7", 0, 5'd7, 32'd77, 1'b0);
`else
    push("wr1_same_r7", 0, 5'd7, 32'd0, 1'b1);
`endif
    check_q();
    commit();
    push("wr1_clr_r7", 0, 5'd7, 32'd77, 1'b0);
    check_q();
    sync();
    wr1_en = 1; wr1_addr = 7; wr1_data = 32'd78;
    busy_set = 1; busy_addr = 7;
    commit();
    push("set_clr_r7", 0, 5'd7, 32'd78, 1'b1);
    check_q();
    sync();
    busy_set = 1; busy_addr = 7;
    commit();
    push("reset_busy_r7", 1, 5'd7, 32'd78, 1'b1);
    check_q();
    sync();
    busy_set = 1; busy_addr = 0;
    commit();
    push("bset_r0", 0, 5'd0, 32'h0, 1'b0);
    check_q();
    sync();
    busy_set = 1; busy_addr = 12;
    commit();
    sync();
    wr0_en = 1; wr0_addr = 12; wr0_data = 32'h1212;
    commit();
    push("wr0_clr_r12", 1, 5'd12, 32'h1212, 1'b0);
    check_q();

    // reset mid-operation
    sync();
    busy_set = 1; busy_addr = 5;
    commit();
    sync();
    busy_set = 1; busy_addr = 6;
    commit();
    push("pre_rst_r5", 0, 5'd5, 32'd20, 1'b1);
    push("pre_rst_r6", 1, 5'd6, 32'h0, 1'b1);
    check_q();
    sync();
    wr0_en = 1; wr0_addr = 5; wr0_data = 32'd55;
    busy_set = 1; busy_addr = 9;
    #2;
    rst = 1'b1;
    push("rst_r5", 0, 5'd5, 32'h0, 1'b0);
    push("rst_r6", 1, 5'd6, 32'h0, 1'b0);
    push("rst_r31", 0, 5'd31, 32'h0, 1'b0);
    push("rst_r8", 1, 5'd8, 32'h0, 1'b0);
    check_q();
    idle();
    sync();
    rst = 1'b0;
    commit();
    push("post_rst_r5", 0, 5'd5, 32'h0, 1'b0);
    push("post_rst_r9", 1, 5'd9, 32'h0, 1'b0);
    check_q();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
